// File: rtl/cpu_pkg.sv
// Constants shared between the control FSM and the fetch stage: controller
// one-hot state codes, opcode field layout and the fetch stage's own states.
package cpu_pkg;

   localparam logic [5:0] STATE_INITIAL = 6'b000001;
   localparam logic [5:0] STATE_FETCH   = 6'b000010;
   localparam logic [5:0] STATE_DECODE  = 6'b000100;
   localparam logic [5:0] STATE_ALU     = 6'b001000;
   localparam logic [5:0] STATE_INCPC   = 6'b010000;
   localparam logic [5:0] STATE_HALT    = 6'b100000;

   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
   localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
   localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
   localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
   localparam logic [OPC_W-1:0] OP_JUMP  = 4'h8;
   localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

   // One-hot so each fetch output is a single state flop.
   typedef enum logic [3:0] {
      F_IDLE = 4'b0001,
      F_REQ  = 4'b0010,
      F_DONE = 4'b0100,
      F_ERR  = 4'b1000
   } fetch_state_e;

endpackage

// File: rtl/fetch_wdog.sv
// Request watchdog: reloads while cleared, counts down while running and
// flags expiry on the TIMEOUT_CYC-th running cycle.
module fetch_wdog #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = i_run && (r_cnt == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: single-beat instruction read during Fetch,
// IR capture, halt decode and PC increment. FETCH_TIMEOUT_EN adds a watchdog.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int RESET_PC    = 0,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        state,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_rdy,
   output logic              halt,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_err
);

   fetch_state_e      r_fsm;
   fetch_state_e      w_fsm_nxt;
   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic              w_is_fetch;
   logic              w_is_incpc;
   logic              w_expire;

   // Exact compares: any illegal (zero or multi-hot) vector matches neither.
   assign w_is_fetch = (state == STATE_FETCH);
   assign w_is_incpc = (state == STATE_INCPC);

`ifdef FETCH_TIMEOUT_EN
   fetch_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (r_fsm != F_REQ),
      .i_run    (r_fsm == F_REQ),
      .o_expire (w_expire)
   );
`else
   logic [31:0] w_unused_tmo;
   assign w_unused_tmo = TIMEOUT_CYC;
   assign w_expire     = 1'b0;
`endif

   // NOTE: clocked state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm <= F_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         F_IDLE: if (w_is_fetch) w_fsm_nxt = F_REQ;
         F_REQ: begin
            // An ack on the expiry cycle still completes the fetch.
            if (mem_ack)       w_fsm_nxt = F_DONE;
            else if (w_expire) w_fsm_nxt = F_ERR;
         end
         F_DONE: if (!w_is_fetch) w_fsm_nxt = F_IDLE;
         F_ERR:  w_fsm_nxt = F_ERR;
         default: w_fsm_nxt = F_IDLE;
      endcase
   end

   always_comb begin
      mem_req   = (r_fsm == F_REQ);
      mem_rdy   = (r_fsm == F_DONE);
`ifdef FETCH_TIMEOUT_EN
      fetch_err = (r_fsm == F_ERR);
`else
      fetch_err = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir <= '0;
         r_pc <= ADDR_W'(RESET_PC);
      end else begin
         if ((r_fsm == F_REQ) && mem_ack) begin
            r_ir <= mem_rdata;
         end
         if (w_is_incpc) begin
            r_pc <= r_pc + 1'b1;
         end
      end
   end

   assign instr    = r_ir;
   assign pc       = r_pc;
   assign mem_addr = r_pc;
   assign halt     = (r_ir[DATA_W-1 -: OPC_W] == OP_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized
// traffic against a transaction-level model. Timeout cases need FETCH_TIMEOUT_EN.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int RST_PC = 0;
   localparam int TMO    = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [5:0]        state;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rdy;
   logic              halt;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] pc;
   logic              fetch_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: what the stage promises after each clock edge.
   int          m_pc;
   logic [15:0] m_ir;
   bit          m_req, m_rdy, m_err;
   int          m_wait;

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .RESET_PC    (RST_PC),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .state     (state),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy),
      .halt      (halt),
      .instr     (instr),
      .pc        (pc),
      .fetch_err (fetch_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input logic [5:0] st, input bit ack, input logic [15:0] rd);
      bool_step: begin
         if (r) begin
            m_pc = RST_PC; m_ir = '0; m_req = 0; m_rdy = 0; m_err = 0; m_wait = 0;
         end else begin
            if (st == STATE_INCPC) m_pc = (m_pc + 1) % (1 << ADDR_W);
            if (m_req) begin
               if (ack) begin
                  m_ir = rd; m_req = 0; m_rdy = 1;
               end else begin
                  m_wait++;
`ifdef FETCH_TIMEOUT_EN
                  if (m_wait == TMO) begin m_req = 0; m_err = 1; end
`endif
               end
            end else if (m_rdy) begin
               if (st != STATE_FETCH) m_rdy = 0;
            end else if (!m_err && st == STATE_FETCH) begin
               m_req = 1; m_wait = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      check("mem_req",   32'(mem_req),   32'(m_req));
      check("mem_addr",  32'(mem_addr),  32'(m_pc));
      check("pc",        32'(pc),        32'(m_pc));
      check("mem_rdy",   32'(mem_rdy),   32'(m_rdy));
      check("instr",     32'(instr),     32'(m_ir));
      check("halt",      32'(halt),      32'(m_ir[15:12] == 4'hF));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
   endtask

   // Called at a negedge: drive, let one posedge happen, then compare.
   task automatic cycle(input bit r, input logic [5:0] st, input bit ack, input logic [15:0] rd);
      rst = r; state = st; mem_ack = ack; mem_rdata = rd;
      @(posedge clk);
      model_step(r, st, ack, rd);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [5:0] st;
      rst = 1'b1; state = '0; mem_ack = 1'b0; mem_rdata = '0;
      m_pc = 0; m_ir = '0; m_req = 0; m_rdy = 0; m_err = 0; m_wait = 0;
      @(negedge clk);

      // Reset
      cycle(1, 6'b000000, 0, '0);
      cycle(1, STATE_INITIAL, 0, '0);
      check("rst_pc", 32'(pc), RST_PC);
      check("rst_req", 32'(mem_req), 0);

      // Fetch with ack three cycles after request
      cycle(0, STATE_FETCH, 0, '0);
      check("t1_req_up", 32'(mem_req), 1);
      cycle(0, STATE_FETCH, 0, '0);
      cycle(0, STATE_FETCH, 0, '0);
      cycle(0, STATE_FETCH, 1, 16'h1234);
      check("t1_instr", 32'(instr), 32'h1234);
      check("t1_rdy", 32'(mem_rdy), 1);
      check("t1_addr", 32'(mem_addr), 0);
      cycle(0, STATE_FETCH, 0, '0);
      cycle(0, STATE_FETCH, 0, '0);
      check("t1_rdy_hold", 32'(mem_rdy), 1);
      check("t1_no_rereq", 32'(mem_req), 0);
      cycle(0, STATE_DECODE, 0, '0);
      check("t1_rdy_drop", 32'(mem_rdy), 0);

      // Ack in the first request cycle, halt opcode
      cycle(0, STATE_INITIAL, 0, '0);
      cycle(0, STATE_FETCH, 0, '0);
      cycle(0, STATE_FETCH, 1, 16'hF000);
      check("t2_rdy", 32'(mem_rdy), 1);
      cycle(0, STATE_DECODE, 0, '0);
      check("t2_halt", 32'(halt), 1);
      check("t2_pc", 32'(pc), 0);

      // PC wrap and freeze
      repeat (255) cycle(0, STATE_INCPC, 0, '0);
      check("t3_pc_ff", 32'(pc), 32'hFF);
      cycle(0, STATE_INCPC, 0, '0);
      check("t3_pc_wrap", 32'(pc), 0);
      for (int i = 0; i < 5; i++) cycle(0, (i % 2) ? STATE_HALT : STATE_ALU, 0, '0);
      check("t3_pc_frozen", 32'(pc), 0);

      // Reset during an outstanding request, late ack ignored
      cycle(0, STATE_INCPC, 0, '0);
      cycle(0, STATE_FETCH, 0, '0);
      check("t4_req_up", 32'(mem_req), 1);
      cycle(1, STATE_FETCH, 0, '0);
      check("t4_req_rst", 32'(mem_req), 0);
      check("t4_pc_rst", 32'(pc), RST_PC);
      cycle(0, STATE_INITIAL, 1, 16'hBEEF);
      check("t4_instr", 32'(instr), 0);
      check("t4_halt", 32'(halt), 0);

      // Stray ack and illegal state vectors
      cycle(0, STATE_ALU, 1, 16'hFFFF);
      check("t5_stray_instr", 32'(instr), 0);
      check("t5_stray_rdy", 32'(mem_rdy), 0);
      cycle(0, 6'b000000, 0, '0);
      check("t5_zero_req", 32'(mem_req), 0);
      cycle(0, 6'b000110, 0, '0);
      check("t5_multi_req", 32'(mem_req), 0);

`ifdef FETCH_TIMEOUT_EN
      // No ack: request drops after TMO cycles, error is sticky
      cycle(1, STATE_INITIAL, 0, '0);
      cycle(0, STATE_FETCH, 0, '0);
      for (int i = 1; i < TMO; i++) begin
         cycle(0, STATE_FETCH, 0, '0);
         check("t6_req_wait", 32'(mem_req), 1);
      end
      cycle(0, STATE_FETCH, 0, '0);
      check("t6_req_drop", 32'(mem_req), 0);
      check("t6_err", 32'(fetch_err), 1);
      cycle(0, STATE_FETCH, 1, 16'h1111);
      cycle(0, STATE_DECODE, 0, '0);
      cycle(0, STATE_FETCH, 0, '0);
      check("t6_err_sticky", 32'(fetch_err), 1);
      check("t6_stall_rdy", 32'(mem_rdy), 0);
      cycle(1, STATE_INITIAL, 0, '0);
      check("t6_err_clr", 32'(fetch_err), 0);
      // Ack on the timeout cycle itself wins
      cycle(0, STATE_FETCH, 0, '0);
      for (int i = 1; i < TMO; i++) cycle(0, STATE_FETCH, 0, '0);
      cycle(0, STATE_FETCH, 1, 16'h2468);
      check("t7_rdy", 32'(mem_rdy), 1);
      check("t7_err", 32'(fetch_err), 0);
      check("t7_instr", 32'(instr), 32'h2468);
`endif

      // Randomized traffic
      cycle(1, STATE_INITIAL, 0, '0);
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: st = STATE_FETCH;
            4:          st = STATE_INCPC;
            5:          st = STATE_DECODE;
            6:          st = STATE_ALU;
            7:          st = STATE_HALT;
            8:          st = STATE_INITIAL;
            default:    st = 6'($urandom);
         endcase
         cycle(($urandom_range(0, 99) == 0), st, ($urandom_range(0, 2) == 0), 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
